// File: rtl/fulladder_inst.sv
// fulladder_inst -- structural full adder built from two half adders, with
// registered copies of sum/carry and a saturating count of carry events.
// Optional build macro: FULLADDER_INST_SELFCHECK_EN adds a behavioural
// reference adder and a sticky mismatch flag on port err.

// Half adder: purely combinational, no clock.
module fulladder_half (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

module fulladder_inst #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    output logic             sum,
    output logic             carry_out,
    output logic             sum_q,
    output logic             carry_q,
    output logic [CNT_W-1:0] carry_cnt
`ifdef FULLADDER_INST_SELFCHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic s1;
    logic c1;
    logic c2;

    logic             sum_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // First stage adds a and b; second stage folds in the carry-in.
    fulladder_half ha1 (
        .x (a),
        .y (b),
        .s (s1),
        .c (c1)
    );

    fulladder_half ha2 (
        .x (s1),
        .y (cin),
        .s (sum),
        .c (c2)
    );

    // The two partial carries can never both be 1, so OR merges them.
    assign carry_out = c1 | c2;

    // Next counter value: step on a carry event, hold once all ones.
    always_comb begin
        cnt_next = cnt_reg;
        if (carry_out && !(&cnt_reg)) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    // Output registers; reset takes priority over any pending increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg   <= 1'b0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sum_reg   <= sum;
            carry_reg <= carry_out;
            cnt_reg   <= cnt_next;
        end
    end

    assign sum_q     = sum_reg;
    assign carry_q   = carry_reg;
    assign carry_cnt = cnt_reg;

`ifdef FULLADDER_INST_SELFCHECK_EN
    logic [1:0] ref_add;
    logic       mismatch;
    logic       err_reg;
    logic       err_next;

    // Behavioural reference compared against the structural result.
    always_comb begin
        ref_add  = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        mismatch = (ref_add != {carry_out, sum});
        err_next = err_reg | mismatch;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_fulladder_inst.sv
// Testbench for fulladder_inst: directed scenarios plus randomized traffic
// checked against an arithmetic reference model. Two instances are used,
// the default counter width and a 2-bit counter for saturation checks.
`timescale 1ns/1ps

module tb_fulladder_inst;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       a;
    logic       b;
    logic       cin;
    logic       sum;
    logic       carry_out;
    logic       sum_q;
    logic       carry_q;
    logic [7:0] carry_cnt;
    logic       sum2;
    logic       carry_out2;
    logic       sum_q2;
    logic       carry_q2;
    logic [1:0] carry_cnt2;
`ifdef FULLADDER_INST_SELFCHECK_EN
    logic       err;
    logic       err2;
`endif

    int n_checks;
    int n_fail;

    // Reference model state
    int m_sum_q;
    int m_carry_q;
    int m_cnt8;
    int m_cnt2;

    fulladder_inst #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .carry_out (carry_out),
        .sum_q     (sum_q),
        .carry_q   (carry_q),
        .carry_cnt (carry_cnt)
`ifdef FULLADDER_INST_SELFCHECK_EN
        ,
        .err       (err)
`endif
    );

    fulladder_inst #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum2),
        .carry_out (carry_out2),
        .sum_q     (sum_q2),
        .carry_q   (carry_q2),
        .carry_cnt (carry_cnt2)
`ifdef FULLADDER_INST_SELFCHECK_EN
        ,
        .err       (err2)
`endif
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    // Advance one rising edge and update the model with the inputs that
    // were stable at that edge; sample 1 ns later.
    task automatic step();
        int total;
        total = int'(a) + int'(b) + int'(cin);
        @(posedge clk);
        if (rst) begin
            m_sum_q = 0; m_carry_q = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            m_sum_q   = total % 2;
            m_carry_q = total / 2;
            if (total >= 2) begin
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
        end
        #1;
    endtask

    task automatic check_regs(input string name);
        n_checks++;
        if (sum_q !== 1'(m_sum_q) || carry_q !== 1'(m_carry_q) ||
            carry_cnt !== 8'(m_cnt8) || carry_cnt2 !== 2'(m_cnt2)) begin
            n_fail++;
            $display("FAIL %s: got sum_q=%b carry_q=%b cnt=%0d cnt2=%0d, expected %0d %0d %0d %0d",
                     name, sum_q, carry_q, carry_cnt, carry_cnt2,
                     m_sum_q, m_carry_q, m_cnt8, m_cnt2);
        end else begin
            $display("ok   %s: sum_q=%b carry_q=%b cnt=%0d cnt2=%0d",
                     name, sum_q, carry_q, carry_cnt, carry_cnt2);
        end
    endtask

    task automatic check_comb(input string name);
        int total;
        total = int'(a) + int'(b) + int'(cin);
        n_checks++;
        if (sum !== 1'(total % 2) || carry_out !== 1'(total / 2) ||
            sum2 !== 1'(total % 2) || carry_out2 !== 1'(total / 2)) begin
            n_fail++;
            $display("FAIL %s: abc=%b%b%b got sum=%b cout=%b, expected %0d %0d",
                     name, a, b, cin, sum, carry_out, total % 2, total / 2);
        end else begin
            $display("ok   %s: abc=%b%b%b sum=%b cout=%b", name, a, b, cin, sum, carry_out);
        end
    endtask

    task automatic test_reset();
        clk_en = 1'b1;
        rst = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
        step();
        step();
        n_checks++;
        if (sum_q !== 1'b0 || carry_q !== 1'b0 || carry_cnt !== 8'd0 || carry_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b %b %0d %0d, expected 0 0 0 0",
                     sum_q, carry_q, carry_cnt, carry_cnt2);
        end else begin
            $display("ok   reset_state: all registers zero");
        end
        check_comb("comb_during_reset");
        rst = 1'b0;
        step();
        n_checks++;
        if (sum_q !== 1'b1 || carry_q !== 1'b1 || carry_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL first_edge: got %b %b %0d, expected 1 1 1", sum_q, carry_q, carry_cnt);
        end else begin
            $display("ok   first_edge: sum_q=1 carry_q=1 cnt=1");
        end
    endtask

    task automatic test_comb_no_clock();
        logic [2:0] v;
        clk_en = 1'b0;
        #10;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, cin} = v;
            #10;
            check_comb("truth_table");
        end
        clk_en = 1'b1;
    endtask

    task automatic test_saturation();
        int exp2 [5];
        exp2 = '{1, 2, 3, 3, 3};
        rst = 1'b1;
        step();
        rst = 1'b0; a = 1'b1; b = 1'b1; cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (carry_cnt2 !== 2'(exp2[i])) begin
                n_fail++;
                $display("FAIL saturate_%0d: got cnt2=%0d, expected %0d", i, carry_cnt2, exp2[i]);
            end else begin
                $display("ok   saturate_%0d: cnt2=%0d", i, carry_cnt2);
            end
        end
        check_regs("saturate_wide");
    endtask

    task automatic test_reset_override();
        rst = 1'b1;
        step();
        rst = 1'b0; a = 1'b1; b = 1'b1; cin = 1'b0;
        step();
        step();
        check_regs("cnt_at_two");
        rst = 1'b1;
        step();
        n_checks++;
        if (carry_cnt !== 8'd0 || carry_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_override: got cnt=%0d cout=%b, expected 0 1", carry_cnt, carry_out);
        end else begin
            $display("ok   reset_override: cnt=0 cout=1");
        end
        rst = 1'b0;
    endtask

    task automatic test_input_change();
        a = 1'b0; b = 1'b1; cin = 1'b1;
        step();
        check_regs("pre_change");
        a = 1'b1; b = 1'b0; cin = 1'b0;
        #1;
        n_checks++;
        if (sum !== 1'b1 || sum_q !== 1'b0) begin
            n_fail++;
            $display("FAIL immediate_sum: got sum=%b sum_q=%b, expected 1 0", sum, sum_q);
        end else begin
            $display("ok   immediate_sum: sum=1 sum_q=0");
        end
        step();
        n_checks++;
        if (sum_q !== 1'b1) begin
            n_fail++;
            $display("FAIL sum_q_follows: got %b, expected 1", sum_q);
        end else begin
            $display("ok   sum_q_follows: sum_q=1");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            {a, b, cin} = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 19) == 0);
            #1;
            check_comb("rand_comb");
            step();
            check_regs("rand_regs");
        end
        rst = 1'b0;
        // Long carry run to push the wide counter into saturation too.
        a = 1'b1; b = 1'b1; cin = 1'b1;
        for (int i = 0; i < 260; i++) begin
            step();
        end
        check_regs("wide_saturate");
    endtask

`ifdef FULLADDER_INST_SELFCHECK_EN
    task automatic test_selfcheck();
        rst = 1'b1;
        step();
        rst = 1'b0; a = 1'b0; b = 1'b1; cin = 1'b1;
        force dut.c2 = 1'b0;
        @(posedge clk); #1;
        release dut.c2;
        step();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b, expected 1", err);
        end else begin
            $display("ok   err_sticky: err=1");
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b, expected 0", err);
        end else begin
            $display("ok   err_clear: err=0");
        end
        rst = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0;
        m_sum_q = 0; m_carry_q = 0; m_cnt8 = 0; m_cnt2 = 0;
        clk_en = 1'b0; rst = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
        test_comb_no_clock();
        test_reset();
        test_saturation();
        test_reset_override();
        test_input_change();
        test_random();
`ifdef FULLADDER_INST_SELFCHECK_EN
        test_selfcheck();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fulladder_inst.md
FULLADDER_INST -- requirements
Module: fulladder_inst

Interface
REQ-001 Parameter CNT_W, default 8: width of the carry-event counter.
REQ-002 Port clk, input, 1: single clock; all registers update on the rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port a, input, 1: addend bit A.
REQ-005 Port b, input, 1: addend bit B.
REQ-006 Port cin, input, 1: carry-in.
REQ-007 Port sum, output, 1: combinational sum, a XOR b XOR cin.
REQ-008 Port carry_out, output, 1: combinational carry, majority(a, b, cin).
REQ-009 Port sum_q, output, 1: sum registered on the clock.
REQ-010 Port carry_q, output, 1: carry_out registered on the clock.
REQ-011 Port carry_cnt, output, CNT_W: count of clock edges sampled with carry_out high; saturates.
REQ-012 Port err, output, 1: sticky self-check mismatch flag; present only when FULLADDER_INST_SELFCHECK_EN is defined (see REQ-024).

Function
REQ-013 The core SHALL be built from two instantiated half-adder submodules plus an OR gate: HA1(a,b) gives s1,c1; HA2(s1,cin) gives sum,c2; carry_out = c1 OR c2.
REQ-014 The half-adder submodule SHALL compute s = x XOR y and c = x AND y, with no clock.
REQ-015 sum and carry_out SHALL be purely combinational, with zero-cycle latency, and valid whether or not clk toggles or rst is asserted.
REQ-016 Truth table, abc -> sum,cout: 000->0,0 001->1,0 010->1,0 011->0,1 100->1,0 101->0,1 110->0,1 111->1,1.
REQ-017 sum_q and carry_q SHALL equal the sum and carry_out values sampled at the previous rising clk edge, giving one-cycle latency.
REQ-018 On each rising edge where rst = 0 and carry_out = 1, carry_cnt SHALL increment by 1.
REQ-019 carry_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap around.
REQ-020 X or Z on any input SHALL NOT be masked: outputs propagate X per standard gate semantics.

Reset
REQ-021 While rst is high at a rising edge: sum_q = 0, carry_q = 0, carry_cnt = 0, and err = 0 when present.
REQ-022 Reset SHALL NOT affect the combinational outputs sum and carry_out.
REQ-023 Reset asserted mid-operation SHALL override the counter increment in the same cycle, so the counter becomes 0 even if carry_out = 1.

Configuration
REQ-024 When macro FULLADDER_INST_SELFCHECK_EN is defined, the module SHALL include a behavioral reference {cout,sum} = a+b+cin, compared each rising edge against the structural outputs.
REQ-025 With FULLADDER_INST_SELFCHECK_EN defined, any mismatch SHALL set err, which stays 1 until rst.
REQ-026 With FULLADDER_INST_SELFCHECK_EN undefined, the err port and all check logic SHALL be absent, and the remaining behaviour is unchanged.

Verification
REQ-027 No clock, step through all 8 abc combinations every 10 ns -> sum and carry_out match REQ-016 within each step.
REQ-028 rst=1 for 2 edges, then a=b=cin=1 and one edge -> sum_q=1, carry_q=1, carry_cnt=1.
REQ-029 CNT_W=2, a=b=1, 5 edges without reset -> carry_cnt reads 1,2,3,3,3.
REQ-030 carry_cnt=2, rst=1 with a=b=1 on one edge -> carry_cnt=0, carry_out stays 1 combinationally.
REQ-031 Input change from 011 to 100 between edges -> sum goes 0->1 immediately, sum_q follows after the next edge.
REQ-032 SELFCHECK build, force the HA2 carry to 0 with abc=011 -> err=1 after the next edge, held until rst.
